message_schedule: RTL
=====================

MESSAGE_SCHEDULE -- requirements
Module: message_schedule

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 64: total schedule words W[0..NUM_ROUNDS-1] emitted per chunk; legal range 17..64.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_en  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  pulse to begin a new 512-bit chunk.
REQ-005 SHALL have port word_valid  input  1  word_in holds a valid message word.
REQ-006 SHALL have port word_in  input  32  big-endian message word from memory read path.
REQ-007 SHALL have port advance  input  1  hash stage requests the next expanded word.
REQ-008 SHALL have port word_ready  output  1  block accepts word_in this cycle.
REQ-009 SHALL have port w_out  output  32  current schedule word W[t].
REQ-010 SHALL have port w_valid  output  1  one-cycle pulse: w_out/round_out newly updated.
REQ-011 SHALL have port round_out  output  8  index t of w_out.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port chunk_done  output  1  one-cycle pulse after W[NUM_ROUNDS-1] is emitted.

Function
REQ-014 SHALL implement states IDLE, LOAD, EXPAND, DONE, held in a registered state variable.
REQ-015 SHALL keep a 16-entry x 32-bit shift window; window[15] is newest, window[0] oldest; each new word shifts in at [15], discarding [0].
REQ-016 IDLE: start=1 -> LOAD, word counter t cleared to 0; start=0 -> stay IDLE; advance and word_valid ignored.
REQ-017 LOAD: word_ready=1 combinationally; on word_valid=1, shift word_in into window, register w_out=word_in, round_out=t, w_valid=1 next cycle, t<=t+1.
REQ-018 LOAD: word_valid=0 -> no shift, w_valid=0, t unchanged (stalls allowed indefinitely).
REQ-019 LOAD: acceptance of word with t=15 -> EXPAND next cycle.
REQ-020 EXPAND: word_ready=0; on advance=1 compute W[t]=sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], modulo 2^32 (carries discarded), shift into window, register to w_out with round_out=t, w_valid=1; t<=t+1.
REQ-021 sigma0(x)=ROTR7(x) xor ROTR18(x) xor SHR3(x); sigma1(x)=ROTR17(x) xor ROTR19(x) xor SHR10(x); all 32-bit.
REQ-022 EXPAND: advance=0 -> window, w_out, round_out, t held; w_valid=0.
REQ-023 EXPAND: emission of t=NUM_ROUNDS-1 -> DONE next cycle.
REQ-024 DONE: chunk_done=1 for exactly one cycle, then IDLE; w_out/round_out hold last values.
REQ-025 start while busy=1 SHALL be ignored (no restart, no counter change).
REQ-026 Latency: word accepted or advance sampled at edge N -> w_valid=1 during cycle after edge N; never two words per cycle.
REQ-027 w_valid SHALL be registered and low whenever no word was emitted on the preceding edge.
REQ-028 t SHALL be 8 bits wide; it never exceeds NUM_ROUNDS-1 while busy.

Reset
REQ-029 reset_en=0 at a clock edge SHALL force state=IDLE, t=0, window all 0, w_out=0, round_out=0, w_valid=0, chunk_done=0; word_ready=0 and busy=0 follow combinationally.
REQ-030 Reset SHALL take priority over start, word_valid and advance, including mid-LOAD or mid-EXPAND; the partially processed chunk is discarded.

Verification
REQ-031 "abc" block: start, words 0x61626380, 14x 0x00000000, 0x00000018, advance held 1 -> W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, chunk_done one cycle after round_out=63, 64 w_valid pulses total.
REQ-032 Stalls: word_valid toggled 1/0 in LOAD and advance toggled in EXPAND -> identical W sequence to REQ-031, w_valid only on accepted cycles.
REQ-033 Reset mid-operation: reset_en=0 at round_out=30 -> next cycle busy=0, w_out=0, w_valid=0; a fresh "abc" run then matches REQ-031.
REQ-034 start pulsed during EXPAND -> ignored; round_out continues incrementing, single chunk_done.
REQ-035 Back-to-back chunks: start asserted in the cycle after chunk_done -> second chunk loads, round_out restarts at 0, W values independent of first chunk.
REQ-036 Random blocks vs. software SHA-256 schedule model, 1000 chunks, random advance/word_valid -> all 64 words match.

Source files
------------

// File: rtl/message_schedule.sv
// SHA-256 message schedule. W[0..15] are loaded from the memory read path,
// then W[16..NUM_ROUNDS-1] are expanded one word per advance request.
module message_schedule #(
   parameter int NUM_ROUNDS = 64
) (
   input  logic        clk,
   input  logic        reset_en,
   input  logic        start,
   input  logic        word_valid,
   input  logic [31:0] word_in,
   input  logic        advance,
   output logic        word_ready,
   output logic [31:0] w_out,
   output logic        w_valid,
   output logic [7:0]  round_out,
   output logic        busy,
   output logic        chunk_done
);
   localparam logic [7:0] LAST_T      = 8'(NUM_ROUNDS - 1);
   localparam logic [7:0] LOAD_LAST_T = 8'd15;

   typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

   state_t      state_reg, state_next;
   logic [7:0]  t_reg;
   logic [31:0] window_reg [16];
   logic [31:0] w_out_reg;
   logic [7:0]  round_out_reg;
   logic        w_valid_reg;
   logic        shift_en;
   logic [31:0] new_word;
   logic [31:0] expanded;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // window[15] = W[t-1], [14] = W[t-2], [9] = W[t-7], [1] = W[t-15], [0] = W[t-16]
   assign expanded = sigma1(window_reg[14]) + window_reg[9]
                   + sigma0(window_reg[1]) + window_reg[0];
   assign shift_en = ((state_reg == LOAD) && word_valid) ||
                     ((state_reg == EXPAND) && advance);
   assign new_word = (state_reg == LOAD) ? word_in : expanded;

   always_ff @(posedge clk) begin
      if (!reset_en) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = LOAD;
         LOAD:    if (word_valid && (t_reg == LOAD_LAST_T)) state_next = EXPAND;
         EXPAND:  if (advance && (t_reg == LAST_T)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      word_ready = (state_reg == LOAD);
      busy       = (state_reg != IDLE);
      chunk_done = (state_reg == DONE);
   end

   // t saturates at the last round so it stays in range through DONE
   always_ff @(posedge clk) begin
      if (!reset_en) begin
         t_reg <= 8'd0;
      end else if ((state_reg == IDLE) && start) begin
         t_reg <= 8'd0;
      end else if (shift_en && (t_reg != LAST_T)) begin
         t_reg <= t_reg + 8'd1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 15; gi++) begin : g_window
         always_ff @(posedge clk) begin
            if (!reset_en) begin
               window_reg[gi] <= 32'd0;
            end else if (shift_en) begin
               window_reg[gi] <= window_reg[gi+1];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset_en) begin
         window_reg[15] <= 32'd0;
      end else if (shift_en) begin
         window_reg[15] <= new_word;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_en) begin
         w_out_reg     <= 32'd0;
         round_out_reg <= 8'd0;
         w_valid_reg   <= 1'b0;
      end else begin
         w_valid_reg <= shift_en;
         if (shift_en) begin
            w_out_reg     <= new_word;
            round_out_reg <= t_reg;
         end
      end
   end

   assign w_out     = w_out_reg;
   assign round_out = round_out_reg;
   assign w_valid   = w_valid_reg;

endmodule
